// File: rtl/g_to_b_stream_if.sv
// Handshake bundle for the Gray-to-binary stream decoder.
// master = producer of Gray words / consumer of decoded words; slave = the decoder.
interface g_to_b_stream_if #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
);
    logic [WIDTH-1:0]     g_in;
    logic                 in_valid;
    logic                 in_ready;
    logic [WIDTH-1:0]     b_out;
    logic                 out_valid;
    logic                 out_ready;
    logic                 first;
    logic                 repeat_w;
    logic                 dir_up;
    logic                 step_err;
    logic [ERR_CNT_W-1:0] err_cnt;

    modport master (
        output g_in, in_valid, out_ready,
        input  in_ready, b_out, out_valid, first, repeat_w, dir_up, step_err, err_cnt
    );

    modport slave (
        input  g_in, in_valid, out_ready,
        output in_ready, b_out, out_valid, first, repeat_w, dir_up, step_err, err_cnt
    );
endinterface

// File: rtl/g_to_b_stream.sv
// Registered Gray-to-binary decoder with single-step checking.
// Stage 1 captures the incoming Gray word together with the previously
// accepted word; stage 2 decodes both, classifies the step and holds the
// results until the downstream consumer takes them.
module g_to_b_stream #(
    parameter int WIDTH     = 4,
    parameter int ERR_CNT_W = 8
) (
    input  logic            clk,
    input  logic            rst,
    g_to_b_stream_if.slave  bus
);
    localparam logic [ERR_CNT_W-1:0] ERR_MAX = '1;

    // Stage 1 registers
    logic                 s1_valid_reg;
    logic [WIDTH-1:0]     s1_g_reg;
    logic [WIDTH-1:0]     s1_gprev_reg;
    logic                 s1_have_ref_reg;

    // Reference (last accepted word) tracking
    logic [WIDTH-1:0]     ref_g_reg;
    logic                 have_ref_reg;

    // Stage 2 / output registers
    logic                 s2_valid_reg;
    logic [WIDTH-1:0]     b_reg;
    logic                 first_reg;
    logic                 repeat_reg;
    logic                 dir_up_reg;
    logic                 step_err_reg;
    logic [ERR_CNT_W-1:0] err_cnt_reg;

    // Handshake qualifiers
    logic                 out_xfer;
    logic                 s2_load;
    logic                 in_ready_int;
    logic                 in_xfer;

    assign out_xfer     = s2_valid_reg & bus.out_ready;
    assign s2_load      = ~s2_valid_reg | out_xfer;
    // Held low during reset so nothing is accepted on a reset edge.
    assign in_ready_int = ~rst & (~s1_valid_reg | s2_load);
    assign in_xfer      = bus.in_valid & in_ready_int;

    // Gray decode: each binary bit is the XOR of all Gray bits at or above it.
    logic [WIDTH-1:0] b_next;
    logic [WIDTH-1:0] b_prev_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_decode
            assign b_next[gi]      = ^s1_g_reg[WIDTH-1:gi];
            assign b_prev_next[gi] = ^s1_gprev_reg[WIDTH-1:gi];
        end
    endgenerate

    // Step classification: zero, exactly one, or several differing bits.
    logic [WIDTH-1:0] diff_next;
    logic             diff_zero_next;
    logic             diff_one_next;
    logic             first_next;
    logic             repeat_next;
    logic             dir_up_next;
    logic             step_err_next;

    assign diff_next      = s1_g_reg ^ s1_gprev_reg;
    assign diff_zero_next = (diff_next == '0);
    // Power-of-two test: a single set bit clears when ANDed with itself minus one.
    assign diff_one_next  = ~diff_zero_next & ((diff_next & (diff_next - WIDTH'(1))) == '0);

    // Flag decode for the word sitting in stage 1.
    always_comb begin
        first_next    = 1'b0;
        repeat_next   = 1'b0;
        dir_up_next   = 1'b0;
        step_err_next = 1'b0;
        if (!s1_have_ref_reg) begin
            first_next = 1'b1;
        end else if (diff_zero_next) begin
            repeat_next = 1'b1;
        end else if (diff_one_next) begin
            dir_up_next = (b_next == (b_prev_next + WIDTH'(1)));
        end else begin
            step_err_next = 1'b1;
        end
    end

    // Pipeline state, reference tracking and saturating error counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg    <= 1'b0;
            s1_g_reg        <= '0;
            s1_gprev_reg    <= '0;
            s1_have_ref_reg <= 1'b0;
            ref_g_reg       <= '0;
            have_ref_reg    <= 1'b0;
            s2_valid_reg    <= 1'b0;
            b_reg           <= '0;
            first_reg       <= 1'b0;
            repeat_reg      <= 1'b0;
            dir_up_reg      <= 1'b0;
            step_err_reg    <= 1'b0;
            err_cnt_reg     <= '0;
        end else begin
            // Every accepted word becomes the next reference, even a bad step,
            // so one glitch produces one error rather than a resync stall.
            if (in_xfer) begin
                s1_g_reg        <= bus.g_in;
                s1_gprev_reg    <= ref_g_reg;
                s1_have_ref_reg <= have_ref_reg;
                ref_g_reg       <= bus.g_in;
                have_ref_reg    <= 1'b1;
            end

            if (in_xfer) begin
                s1_valid_reg <= 1'b1;
            end else if (s2_load) begin
                s1_valid_reg <= 1'b0;
            end

            if (s2_load) begin
                s2_valid_reg <= s1_valid_reg;
                if (s1_valid_reg) begin
                    b_reg        <= b_next;
                    first_reg    <= first_next;
                    repeat_reg   <= repeat_next;
                    dir_up_reg   <= dir_up_next;
                    step_err_reg <= step_err_next;
                end
            end

            if (out_xfer && step_err_reg && (err_cnt_reg != ERR_MAX)) begin
                err_cnt_reg <= err_cnt_reg + ERR_CNT_W'(1);
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = s2_valid_reg;
    assign bus.b_out     = b_reg;
    assign bus.first     = first_reg;
    assign bus.repeat_w  = repeat_reg;
    assign bus.dir_up    = dir_up_reg;
    assign bus.step_err  = step_err_reg;
    assign bus.err_cnt   = err_cnt_reg;
endmodule

// File: tb/tb_g_to_b_stream.sv
// Bench for g_to_b_stream (WIDTH=4, ERR_CNT_W=2): a reference model predicts
// each accepted word's outputs into a queue, popped on every output transfer.
module tb_g_to_b_stream;
    logic clk = 1'b0;
    logic rst = 1'b1;

    g_to_b_stream_if #(.WIDTH(4), .ERR_CNT_W(2)) bus ();

    g_to_b_stream #(.WIDTH(4), .ERR_CNT_W(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] b;
        logic       first;
        logic       rep;
        logic       dir;
        logic       step;
        logic [1:0] err;
    } obs_t;

    obs_t       q[$];
    logic [3:0] mref;
    bit         mref_valid;
    int         mcnt;
    int         cyc;
    int         n_vec;
    int         n_bad;

    // Reference model: predict outputs for an accepted Gray word.
    task automatic push_word(input logic [3:0] g);
        obs_t       e;
        logic [3:0] b;
        logic [3:0] bp;
        int         d;
        b[3]  = g[3];
        bp[3] = mref[3];
        for (int i = 2; i >= 0; i--) begin
            b[i]  = b[i+1] ^ g[i];
            bp[i] = bp[i+1] ^ mref[i];
        end
        d = $countones(g ^ mref);
        e = '0;
        e.b = b;
        if (!mref_valid)  e.first = 1'b1;
        else if (d == 0)  e.rep   = 1'b1;
        else if (d == 1)  e.dir   = (b == 4'(bp + 4'd1));
        else              e.step  = 1'b1;
        e.err = 2'(mcnt);
        if (e.step && mcnt < 3) mcnt++;
        mref       = g;
        mref_valid = 1'b1;
        q.push_back(e);
    endtask

    // One clock: sample handshakes at negedge, update scoreboard, advance past posedge.
    task automatic tick(output bit seen, output bit ok, output bit acc,
                        output obs_t got, output obs_t exp);
        @(negedge clk);
        seen = bus.out_valid && bus.out_ready && !rst;
        acc  = bus.in_valid && bus.in_ready;
        got  = {bus.b_out, bus.first, bus.repeat_w, bus.dir_up, bus.step_err, bus.err_cnt};
        ok   = 1'b0;
        exp  = '0;
        if (seen) begin
            if (q.size() > 0) begin
                exp = q.pop_front();
                ok  = 1'b1;
            end
            $display("cycle %0d out b=%0d first=%0b repeat_w=%0b dir_up=%0b step_err=%0b err_cnt=%0d",
                     cyc, bus.b_out, bus.first, bus.repeat_w, bus.dir_up, bus.step_err, bus.err_cnt);
        end
        if (acc) push_word(bus.g_in);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic do_reset();
        bit seen, ok, acc;
        obs_t got, exp;
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick(seen, ok, acc, got, exp);
        tick(seen, ok, acc, got, exp);
        rst = 1'b0;
        q.delete();
        mref_valid = 1'b0;
        mref       = '0;
        mcnt       = 0;
    endtask

    task automatic test_reset();
        bit seen, ok, acc;
        obs_t got, exp;
        bus.in_valid  = 1'b1;
        bus.g_in      = 4'b0101;
        bus.out_ready = 1'b1;
        rst = 1'b1;
        tick(seen, ok, acc, got, exp);
        tick(seen, ok, acc, got, exp);
        n_vec++;
        if (bus.in_ready !== 1'b0) begin
            n_bad++; $display("FAIL reset_in_ready: got %b want 0", bus.in_ready);
        end
        n_vec++;
        if (bus.out_valid !== 1'b0) begin
            n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid);
        end
        got = {bus.b_out, bus.first, bus.repeat_w, bus.dir_up, bus.step_err, bus.err_cnt};
        n_vec++;
        if (got !== obs_t'(0)) begin
            n_bad++; $display("FAIL reset_outputs: got 0x%h want 0x000 (b,first,repeat,dir,step,err)", got);
        end
        bus.in_valid = 1'b0;
        rst = 1'b0;
        #1;
        n_vec++;
        if (bus.in_ready !== 1'b1) begin
            n_bad++; $display("FAIL reset_release_in_ready: got %b want 1", bus.in_ready);
        end
        q.delete();
        mref_valid = 1'b0;
        mref       = '0;
        mcnt       = 0;
    endtask

    task automatic test_basic();
        bit seen, ok, acc;
        obs_t got, exp;
        logic [3:0] w[$] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010};
        int idx = 0, outs = 0, acc_cyc = -1, out_first = -1, out_last = -1;
        do_reset();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 30 && (idx < w.size() || q.size() > 0); t++) begin
            bus.in_valid = (idx < w.size());
            if (idx < w.size()) bus.g_in = w[idx];
            tick(seen, ok, acc, got, exp);
            if (acc) begin
                if (acc_cyc < 0) acc_cyc = cyc;
                idx++;
            end
            if (seen) begin
                outs++;
                if (out_first < 0) out_first = cyc;
                out_last = cyc;
                n_vec++;
                if (!ok || got !== exp) begin
                    n_bad++; $display("FAIL basic_word: got 0x%h want 0x%h (b,first,repeat,dir,step,err)", got, exp);
                end
            end
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (outs != 4) begin n_bad++; $display("FAIL basic_count: got %0d want 4", outs); end
        n_vec++;
        if (out_first - acc_cyc != 2) begin
            n_bad++; $display("FAIL basic_latency: got %0d want 2", out_first - acc_cyc);
        end
        n_vec++;
        if (out_last - out_first != 3) begin
            n_bad++; $display("FAIL basic_throughput: got %0d want 3", out_last - out_first);
        end
        n_vec++;
        if (bus.err_cnt !== 2'd0) begin n_bad++; $display("FAIL basic_err_cnt: got %0d want 0", bus.err_cnt); end
    endtask

    task automatic test_wrap();
        bit seen, ok, acc;
        obs_t got, exp;
        logic [3:0] w[$] = '{4'b1001, 4'b1000, 4'b0000, 4'b1000};
        logic [3:0] want_b[4] = '{4'd14, 4'd15, 4'd0, 4'd15};
        int idx = 0, outs = 0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 30 && (idx < w.size() || q.size() > 0); t++) begin
            bus.in_valid = (idx < w.size());
            if (idx < w.size()) bus.g_in = w[idx];
            tick(seen, ok, acc, got, exp);
            if (acc) idx++;
            if (seen) begin
                n_vec++;
                if (!ok || got !== exp || (outs < 4 && got.b !== want_b[outs])) begin
                    n_bad++; $display("FAIL wrap_word: got 0x%h want 0x%h (b,first,repeat,dir,step,err)", got, exp);
                end
                outs++;
            end
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (outs != 4) begin n_bad++; $display("FAIL wrap_count: got %0d want 4", outs); end
    endtask

    task automatic test_illegal();
        bit seen, ok, acc;
        obs_t got, exp;
        logic [3:0] w[$] = '{4'b0000, 4'b0011, 4'b0011};
        int idx = 0, outs = 0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 30 && (idx < w.size() || q.size() > 0); t++) begin
            bus.in_valid = (idx < w.size());
            if (idx < w.size()) bus.g_in = w[idx];
            tick(seen, ok, acc, got, exp);
            if (acc) idx++;
            if (seen) begin
                outs++;
                n_vec++;
                if (!ok || got !== exp) begin
                    n_bad++; $display("FAIL illegal_word: got 0x%h want 0x%h (b,first,repeat,dir,step,err)", got, exp);
                end
            end
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (outs != 3) begin n_bad++; $display("FAIL illegal_count: got %0d want 3", outs); end
        n_vec++;
        if (bus.err_cnt !== 2'd1) begin n_bad++; $display("FAIL illegal_err_cnt: got %0d want 1", bus.err_cnt); end
    endtask

    task automatic test_backpressure();
        bit seen, ok, acc;
        obs_t got, exp;
        logic [3:0] w[$] = '{4'b0000, 4'b0001, 4'b0011, 4'b0010, 4'b0110};
        int idx = 0, outs = 0;
        do_reset();
        bus.out_ready = 1'b0;
        for (int t = 0; t < 4; t++) begin
            bus.in_valid = 1'b1;
            bus.g_in = w[idx];
            tick(seen, ok, acc, got, exp);
            if (acc) idx++;
            if (t == 1 || t == 3) begin
                n_vec++;
                if (bus.out_valid !== 1'b1 || bus.b_out !== 4'd0) begin
                    n_bad++; $display("FAIL bp_hold: got valid=%b b=%0d want valid=1 b=0", bus.out_valid, bus.b_out);
                end
            end
        end
        n_vec++;
        if (idx != 2) begin n_bad++; $display("FAIL bp_accepts: got %0d want 2", idx); end
        n_vec++;
        if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int t = 0; t < 30 && (idx < w.size() || q.size() > 0); t++) begin
            bus.in_valid = (idx < w.size());
            if (idx < w.size()) bus.g_in = w[idx];
            tick(seen, ok, acc, got, exp);
            if (acc) idx++;
            if (seen) begin
                n_vec++;
                if (!ok || got !== exp || got.b !== 4'(outs)) begin
                    n_bad++; $display("FAIL bp_word: got 0x%h want 0x%h (b,first,repeat,dir,step,err)", got, exp);
                end
                outs++;
            end
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (outs != 5) begin n_bad++; $display("FAIL bp_count: got %0d want 5", outs); end
    endtask

    task automatic test_saturation();
        bit seen, ok, acc;
        obs_t got, exp;
        int idx = 0, outs = 0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 60 && (idx < 16 || q.size() > 0); t++) begin
            bus.in_valid = (idx < 16);
            bus.g_in = idx[0] ? 4'b0011 : 4'b0000;
            tick(seen, ok, acc, got, exp);
            if (acc) idx++;
            if (seen) begin
                outs++;
                n_vec++;
                if (!ok || got !== exp) begin
                    n_bad++; $display("FAIL sat_word: got 0x%h want 0x%h (b,first,repeat,dir,step,err)", got, exp);
                end
            end
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (outs != 16) begin n_bad++; $display("FAIL sat_count: got %0d want 16", outs); end
        n_vec++;
        if (bus.err_cnt !== 2'd3) begin n_bad++; $display("FAIL sat_err_cnt: got %0d want 3", bus.err_cnt); end
    endtask

    task automatic test_reset_in_flight();
        bit seen, ok, acc;
        obs_t got, exp;
        logic [3:0] w[$] = '{4'b0000, 4'b0011};
        logic [3:0] v[$] = '{4'b0110, 4'b0111};
        int idx = 0, outs = 0;
        do_reset();
        bus.out_ready = 1'b1;
        for (int t = 0; t < 30 && (idx < w.size() || q.size() > 0); t++) begin
            bus.in_valid = (idx < w.size());
            if (idx < w.size()) bus.g_in = w[idx];
            tick(seen, ok, acc, got, exp);
            if (acc) idx++;
            if (seen) begin
                n_vec++;
                if (!ok || got !== exp) begin
                    n_bad++; $display("FAIL rif_pre_word: got 0x%h want 0x%h (b,first,repeat,dir,step,err)", got, exp);
                end
            end
        end
        n_vec++;
        if (bus.err_cnt !== 2'd1) begin n_bad++; $display("FAIL rif_pre_err_cnt: got %0d want 1", bus.err_cnt); end
        bus.out_ready = 1'b0;
        idx = 0;
        for (int t = 0; t < 3; t++) begin
            bus.in_valid = (idx < v.size());
            if (idx < v.size()) bus.g_in = v[idx];
            tick(seen, ok, acc, got, exp);
            if (acc) idx++;
        end
        n_vec++;
        if (idx != 2) begin n_bad++; $display("FAIL rif_in_flight: got %0d want 2", idx); end
        bus.in_valid = 1'b0;
        rst = 1'b1;
        tick(seen, ok, acc, got, exp);
        rst = 1'b0;
        q.delete();
        mref_valid = 1'b0;
        mref       = '0;
        mcnt       = 0;
        #1;
        n_vec++;
        if (bus.out_valid !== 1'b0 || bus.err_cnt !== 2'd0) begin
            n_bad++; $display("FAIL rif_after_reset: got valid=%b err=%0d want valid=0 err=0", bus.out_valid, bus.err_cnt);
        end
        n_vec++;
        if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL rif_in_ready: got %b want 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        idx = 0;
        for (int t = 0; t < 20 && (idx < 1 || q.size() > 0); t++) begin
            bus.in_valid = (idx < 1);
            bus.g_in = 4'b1010;
            tick(seen, ok, acc, got, exp);
            if (acc) idx++;
            if (seen) begin
                outs++;
                n_vec++;
                if (!ok || got !== exp || got.first !== 1'b1 || got.step !== 1'b0) begin
                    n_bad++; $display("FAIL rif_post_word: got 0x%h want 0x%h (b,first,repeat,dir,step,err)", got, exp);
                end
            end
        end
        bus.in_valid = 1'b0;
        n_vec++;
        if (outs != 1) begin n_bad++; $display("FAIL rif_post_count: got %0d want 1", outs); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "bench did not complete");
    end

    initial begin
        n_vec = 0;
        n_bad = 0;
        cyc   = 0;
        mcnt  = 0;
        mref  = '0;
        mref_valid    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.g_in      = '0;
        bus.out_ready = 1'b0;
        test_reset();
        test_basic();
        test_wrap();
        test_illegal();
        test_backpressure();
        test_saturation();
        test_reset_in_flight();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule

// File: doc/g_to_b_stream.md
Name: g_to_b_stream

Overview:
- Registered Gray-to-binary decoder for a streamed Gray-coded counter value, such as a position or pointer word produced by the binary-to-Gray encoders in this design.
- Accepts Gray words over a valid/ready handshake and decodes them to binary in a 2-stage elastic pipeline.
- Checks every accepted word against the previous one for the single-bit-step Gray property.
- Reports decoded value, count direction, repeat and step-error flags, and a saturating error count.

Parameters:
WIDTH, 4, bit width of Gray input and binary output (minimum 2)
ERR_CNT_W, 8, width of saturating step-error counter

Ports:
clk  input  1  single clock; all logic on rising edge
rst  input  1  synchronous, active-high reset
g_in  input  WIDTH  Gray-coded input word
in_valid  input  1  g_in valid
in_ready  output  1  block can accept g_in this cycle
b_out  output  WIDTH  decoded binary word
out_valid  output  1  b_out and flags valid
out_ready  input  1  downstream accepts output this cycle
first  output  1  word is first accepted since reset (no step check)
repeat_w  output  1  Gray word identical to previous accepted word
dir_up  output  1  1 = b_out is previous+1 mod 2^WIDTH, 0 = previous-1 (meaningful only when first=0, repeat_w=0, step_err=0)
step_err  output  1  Gray word differs from previous accepted word in 2 or more bits
err_cnt  output  ERR_CNT_W  count of step_err words transferred out, saturating

Behaviour:
- Reset, applied on a clk edge with rst=1, wins over all other activity:
  - in_ready=0 during rst; 1 on the first cycle after rst deasserts.
  - out_valid=0, b_out=0, first=0, repeat_w=0, dir_up=0, step_err=0, err_cnt=0.
  - Both stage valids, the previous-word reference and its have-reference flag are cleared.
  - Words in flight when rst asserts are discarded; the next accepted word is flagged first=1.
- Input transfer occurs on a cycle with in_valid and in_ready both high. Output transfer occurs on a cycle with out_valid and out_ready both high.
- Stage 1, capture:
  - Registers g_in, the previous accepted Gray word and the have-reference flag.
  - The reference register updates to g_in on every input transfer.
- Stage 2, decode and output registers:
  - b[WIDTH-1] = g[WIDTH-1]; b[i] = b[i+1] XOR g[i] for i from WIDTH-2 down to 0.
  - d = popcount(g XOR g_prev).
  - Without reference: first=1 and the other flags are 0.
  - d=0: repeat_w=1.
  - d=1: dir_up = (b == b_prev+1 mod 2^WIDTH), where b_prev is decoded from the stored previous Gray word.
  - d>=2: step_err=1 and dir_up=0.
  - A word with step_err still becomes the reference for the next check; there is no resync stall.
- Elastic pipeline:
  - stage2 loads when it is empty or an output transfer occurs.
  - stage1 advances when stage2 loads.
  - in_ready = !s1_valid || stage2 loads (combinational from out_ready).
- Timing and capacity:
  - Latency: an input accepted at edge N produces out_valid at edge N+2 when out_ready is held high.
  - Throughput: 1 word/cycle.
  - Capacity: 2 words; no word is ever dropped or duplicated.
- b_out and all flags hold stable while out_valid=1 and out_ready=0.
- err_cnt increments by 1 on each output transfer with step_err=1 and holds at 2^ERR_CNT_W-1 when saturated.
- Wrap-around is legal: the Gray top-to-zero step (1000 to 0000 for WIDTH=4) decodes as 15 to 0 with dir_up=1, and the reverse step gives dir_up=0.

Test Plan:
1. WIDTH=4, after rst, stream g 0000,0001,0011,0010 with out_ready=1 -> b_out 0,1,2,3 appear from 2 cycles after the first accept, one per cycle; first=1 only on the first word; dir_up=1 on words 2-4; err_cnt=0.
2. Wrap: g 1001,1000,0000,1000 -> b 14,15,0,15; dir_up 1,1 then 0 on the final step; step_err=0 throughout.
3. Illegal step and repeat: g 0000,0011,0011 -> word 2 step_err=1 with err_cnt 1 after its transfer; word 3 repeat_w=1, step_err=0, err_cnt remains 1.
4. Backpressure: in_valid=1 continuously with out_ready=0 for 4 cycles -> in_ready drops after 2 accepts; b_out stays stable; after out_ready=1 the sequence resumes with no loss or duplication.
5. Saturation with ERR_CNT_W=2: alternate g 0000,0011 eight times -> err_cnt reaches 3 and holds at 3.
6. rst asserted for 1 cycle with 2 words in flight -> next cycle out_valid=0 and err_cnt=0; the next word is accepted with first=1 and no step_err regardless of its value.
